nexys_starship_spawn_ctrl: RTL and testbench

Spawn scheduler for Nexys Starship monsters. It consumes the four per-direction random bits from the PRNG and arbitrates round-robin, so at most one monster spawns per game tick. It enforces a global spawn cooldown and a cap on simultaneously active monsters. It ages live monsters, turns un-killed timeouts into ship hits, and owns the lives counter and the game-over state.

---
 rtl/nexys_starship_spawn_ctrl.sv | 158 +++++++++++++++
 tb/tb_nexys_starship_spawn_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_spawn_ctrl.sv
// Spawn scheduler: round-robin one-spawn-per-tick arbiter with cooldown, occupancy cap,
// monster ageing/timeouts, lives and game state. All outputs registered (1-cycle latency), no backpressure.
module nexys_starship_spawn_ctrl #(
    parameter int MAX_ACTIVE     = 2,
    parameter int COOLDOWN_TICKS = 4,
    parameter int TIMEOUT_TICKS  = 32,
    parameter int LIVES          = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       tick,
    input  logic       top_random,
    input  logic       btm_random,
    input  logic       left_random,
    input  logic       right_random,
    input  logic [3:0] kill,
    output logic [3:0] spawn,
    output logic [3:0] hit,
    output logic [3:0] active,
    output logic [2:0] lives,
    output logic       running,
    output logic       game_over
);
    // State bits double as the running/game_over outputs.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [2:0] MAX_ACT_W  = 3'(MAX_ACTIVE);
    localparam logic [7:0] COOLDOWN_W = 8'(COOLDOWN_TICKS);
    localparam logic [7:0] TIMEOUT_W  = 8'(TIMEOUT_TICKS);
    localparam logic [2:0] LIVES_W    = 3'(LIVES);

    logic [1:0]      state_q, state_d;
    logic [3:0]      spawn_q, spawn_d;
    logic [3:0]      hit_q, hit_d;
    logic [3:0]      active_q, active_d;
    logic [2:0]      lives_q, lives_d;
    logic [7:0]      cd_q, cd_d;
    logic [1:0]      rr_q, rr_d;
    logic [3:0][7:0] age_q, age_d;

    logic            run;
    logic [3:0]      req, timeout, kill_eff, hit_vec;
    logic [2:0]      n_act, loss, lives_after;
    logic            gnt_vld, grant;
    logic [1:0]      gnt_idx, idx;
    logic [3:0][7:0] age_inc;

    always_comb begin
        run      = (state_q == ST_RUN);
        req      = {right_random, left_random, btm_random, top_random} & ~active_q;
        gnt_vld  = 1'b0;
        gnt_idx  = 2'd0;
        idx      = 2'd0;
        n_act    = 3'd0;
        loss     = 3'd0;
        age_inc  = '0;
        timeout  = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_q + 2'(k);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        kill_eff = run ? (kill & active_q) : 4'd0;
        for (int d = 0; d < 4; d++) begin
            age_inc[d] = age_q[d] + 8'd1;
            timeout[d] = run && tick && active_q[d] && (age_inc[d] == TIMEOUT_W);
            n_act      = n_act + {2'b00, active_q[d]};
        end
        // A kill landing on the timeout tick saves the ship.
        hit_vec = timeout & ~kill_eff;
        for (int d = 0; d < 4; d++) begin
            loss = loss + {2'b00, hit_vec[d]};
        end
        lives_after = (loss >= lives_q) ? 3'd0 : (lives_q - loss);
        grant = run && tick && (cd_q == 8'd0) && (n_act < MAX_ACT_W) && gnt_vld;
    end

    always_comb begin
        state_d  = state_q;
        spawn_d  = 4'd0;
        hit_d    = 4'd0;
        active_d = active_q;
        lives_d  = lives_q;
        cd_d     = cd_q;
        rr_d     = rr_q;
        age_d    = age_q;
        if (!run) begin
            if (start) begin
                state_d  = ST_RUN;
                lives_d  = LIVES_W;
                active_d = 4'd0;
                age_d    = '0;
                cd_d     = 8'd0;
                rr_d     = 2'd3;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (tick && active_q[d]) begin
                    age_d[d] = age_inc[d];
                end
                if (kill_eff[d] || hit_vec[d]) begin
                    active_d[d] = 1'b0;
                    age_d[d]    = 8'd0;
                end
            end
            if (grant) begin
                cd_d = COOLDOWN_W;
                rr_d = gnt_idx;
            end else if (tick && (cd_q != 8'd0)) begin
                cd_d = cd_q - 8'd1;
            end
            hit_d   = hit_vec;
            lives_d = lives_after;
            if (lives_after == 3'd0) begin
                state_d  = ST_OVER;
                active_d = 4'd0;
            end else if (grant) begin
                spawn_d[gnt_idx]  = 1'b1;
                active_d[gnt_idx] = 1'b1;
                age_d[gnt_idx]    = 8'd0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            spawn_q  <= 4'd0;
            hit_q    <= 4'd0;
            active_q <= 4'd0;
            lives_q  <= 3'd0;
            cd_q     <= 8'd0;
            rr_q     <= 2'd3;
            age_q    <= '0;
        end else begin
            state_q  <= state_d;
            spawn_q  <= spawn_d;
            hit_q    <= hit_d;
            active_q <= active_d;
            lives_q  <= lives_d;
            cd_q     <= cd_d;
            rr_q     <= rr_d;
            age_q    <= age_d;
        end
    end

    assign spawn     = spawn_q;
    assign hit       = hit_q;
    assign active    = active_q;
    assign lives     = lives_q;
    assign running   = state_q[0];
    assign game_over = state_q[1];
endmodule

// File: tb/tb_nexys_starship_spawn_ctrl.sv
// Bench for nexys_starship_spawn_ctrl: behavioural model feeds a scoreboard queue, plus directed scenarios.
module tb_nexys_starship_spawn_ctrl;
    localparam int MAX_ACTIVE     = 2;
    localparam int COOLDOWN_TICKS = 4;
    localparam int TIMEOUT_TICKS  = 8;
    localparam int LIVES          = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       top_random = 1'b0, btm_random = 1'b0, left_random = 1'b0, right_random = 1'b0;
    logic [3:0] kill = 4'd0;
    logic [3:0] spawn, hit, active;
    logic [2:0] lives;
    logic       running, game_over;

    nexys_starship_spawn_ctrl #(
        .MAX_ACTIVE(MAX_ACTIVE), .COOLDOWN_TICKS(COOLDOWN_TICKS),
        .TIMEOUT_TICKS(TIMEOUT_TICKS), .LIVES(LIVES)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .start(start), .tick(tick),
        .top_random(top_random), .btm_random(btm_random),
        .left_random(left_random), .right_random(right_random),
        .kill(kill), .spawn(spawn), .hit(hit), .active(active),
        .lives(lives), .running(running), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] spawn;
        logic [3:0] hit;
        logic [3:0] active;
        logic [2:0] lives;
        logic       running;
        logic       game_over;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: 0 idle, 1 run, 2 over
    int         m_state;
    int         m_lives;
    logic [3:0] m_active;
    int         m_age[4];
    int         m_cd;
    int         m_rr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_active = 4'd0; m_cd = 0; m_rr = 3;
        for (int d = 0; d < 4; d++) m_age[d] = 0;
    endtask

    task automatic model_step(input logic st, input logic tk, input logic [3:0] rnd,
                              input logic [3:0] kl, output exp_t e);
        logic [3:0] prev, req, tmo, hits;
        int         g, n, lost, d;
        e = '0;
        hits = 4'd0;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_lives = LIVES; m_active = 4'd0; m_cd = 0; m_rr = 3;
                for (int i = 0; i < 4; i++) m_age[i] = 0;
            end
        end else begin
            prev = m_active;
            tmo  = 4'd0;
            g    = -1;
            n    = 0;
            for (int i = 0; i < 4; i++) if (prev[i]) n++;
            if (tk) begin
                req = rnd & ~prev;
                if (m_cd == 0 && n < MAX_ACTIVE) begin
                    for (int k = 1; k <= 4; k++) begin
                        d = (m_rr + k) % 4;
                        if (g < 0 && req[d]) g = d;
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (prev[i]) begin
                        m_age[i]++;
                        if (m_age[i] == TIMEOUT_TICKS) tmo[i] = 1'b1;
                    end
                end
                if (g >= 0) begin
                    m_cd = COOLDOWN_TICKS;
                    m_rr = g;
                end else if (m_cd > 0) begin
                    m_cd--;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (kl[i] && prev[i]) begin
                    m_active[i] = 1'b0; m_age[i] = 0;
                end else if (tmo[i]) begin
                    hits[i] = 1'b1; m_active[i] = 1'b0; m_age[i] = 0;
                end
            end
            lost = 0;
            for (int i = 0; i < 4; i++) if (hits[i]) lost++;
            m_lives = (lost >= m_lives) ? 0 : m_lives - lost;
            if (m_lives == 0) begin
                m_state  = 2;
                m_active = 4'd0;
            end else if (g >= 0) begin
                e.spawn[g]  = 1'b1;
                m_active[g] = 1'b1;
                m_age[g]    = 0;
            end
        end
        e.hit       = hits;
        e.active    = m_active;
        e.lives     = 3'(m_lives);
        e.running   = (m_state == 1);
        e.game_over = (m_state == 2);
    endtask

    task automatic step(input logic st, input logic tk, input logic [3:0] rnd, input logic [3:0] kl);
        exp_t e;
        start = st; tick = tk; kill = kl;
        {right_random, left_random, btm_random, top_random} = rnd;
        model_step(st, tk, rnd, kl, e);
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            chk("spawn", {4'd0, spawn}, {4'd0, e.spawn});
            chk("hit", {4'd0, hit}, {4'd0, e.hit});
            chk("active", {4'd0, active}, {4'd0, e.active});
            chk("lives", {5'd0, lives}, {5'd0, e.lives});
            chk("running", {7'd0, running}, {7'd0, e.running});
            chk("game_over", {7'd0, game_over}, {7'd0, e.game_over});
        end
        start = 1'b0; tick = 1'b0; kill = 4'd0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_lives", {5'd0, lives}, 8'd0);
        chk("rst_running", {7'd0, running}, 8'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // Scenario A: all requests high, tick every 10 cycles
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk("start_lives", {5'd0, lives}, 8'(LIVES));
        for (int t = 1; t <= 12; t++) begin
            step(1'b0, 1'b1, 4'hF, 4'h0);
            if (t == 1)  chk("spawn_t1", {4'd0, spawn}, 8'h01);
            if (t >= 2 && t <= 5) chk("spawn_cool", {4'd0, spawn}, 8'h00);
            if (t == 6)  chk("spawn_t6", {4'd0, spawn}, 8'h02);
            if (t == 11) chk("spawn_t11", {4'd0, spawn}, 8'h04);
            for (int c = 0; c < 9; c++)
                step(1'b0, 1'b0, 4'hF, (t == 6 && c == 0) ? 4'b0001 : 4'h0);
            if (t == 6) chk("kill_active", {4'd0, active}, 8'h02);
        end

        // Async reset mid-run
        #3;
        Reset = 1'b0;
        #1;
        chk("arst_active", {4'd0, active}, 8'h00);
        chk("arst_lives", {5'd0, lives}, 8'h00);
        chk("arst_running", {7'd0, running}, 8'h00);
        model_reset();
        @(posedge Clk); #3;
        Reset = 1'b1;
        @(posedge Clk); #1;

        // Scenario B: timeout, kill-on-timeout, game over with discarded spawn
        step(1'b1, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'b0001, 4'h0);
        chk("b_spawn", {4'd0, spawn}, 8'h01);
        for (int i = 0; i < TIMEOUT_TICKS - 1; i++) step(1'b0, 1'b1, 4'h0, 4'h0);
        chk("b_no_hit_early", {4'd0, hit}, 8'h00);
        step(1'b0, 1'b1, 4'h0, 4'h0);
        chk("b_hit", {4'd0, hit}, 8'h01);
        chk("b_lives", {5'd0, lives}, 8'(LIVES - 1));
        chk("b_active", {4'd0, active}, 8'h00);
        step(1'b0, 1'b1, 4'b0001, 4'h0);
        for (int i = 0; i < TIMEOUT_TICKS - 1; i++) step(1'b0, 1'b1, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'b0001);
        chk("kt_hit", {4'd0, hit}, 8'h00);
        chk("kt_lives", {5'd0, lives}, 8'(LIVES - 1));
        chk("kt_active", {4'd0, active}, 8'h00);
        step(1'b0, 1'b1, 4'b0001, 4'h0);
        for (int i = 0; i < TIMEOUT_TICKS - 1; i++) step(1'b0, 1'b1, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'b0010, 4'h0);
        chk("go_spawn", {4'd0, spawn}, 8'h00);
        chk("go_hit", {4'd0, hit}, 8'h01);
        chk("go_lives", {5'd0, lives}, 8'h00);
        chk("go_flag", {7'd0, game_over}, 8'h01);
        chk("go_running", {7'd0, running}, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 4'hF);
        chk("go_hold", {5'd0, lives}, 8'h00);
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk("restart_lives", {5'd0, lives}, 8'(LIVES));
        chk("restart_running", {7'd0, running}, 8'h01);

        // Random phase
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
